data_mem_ctrl: RTL and testbench

- Byte-addressable data memory with an integrated load/store unit for the RV32 datapath.
- Performs byte, half and word loads (sign- or zero-extended) and stores with byte enables.
- Enforces a protected low address window and bounds checking, and splits word-crossing misaligned accesses into two internal cycles.
- Sits between the execute stage and the memory array and uses a valid/ready request and response handshake; it replaces the bare combinational-read RAM.

---
 rtl/data_mem_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressable data memory with an integrated RV32 load/store unit.
// Byte/half/word loads (sign- or zero-extended) and byte-enabled stores, with a
// protected low window, bounds checking, and an IDLE/ACC/ACC2/RESP access sequencer.
// Build option: define MISALIGN_SPLIT_EN to split word-crossing accesses over two
// array cycles (ACC then ACC2); without it every misaligned access faults.
// dbg_state exposes the sequencer state for checkers.
//
// Handshake: a request is taken on a rising edge where req_valid && req_ready.
// All req_* fields are captured at that edge and req_ready stays low until the
// cycle after the single-cycle resp_valid pulse. Responses cannot be stalled.
module data_mem_ctrl #(
    parameter int DEPTH_BYTES = 256,
    parameter int PROT_LIMIT  = 24,
    parameter     INIT_FILE   = "ram_data.mem"
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [1:0]  dbg_state
);

    localparam int WORDS = DEPTH_BYTES / 4;
    localparam int IDX_W = $clog2(WORDS);
    localparam int AW    = IDX_W + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
`ifdef MISALIGN_SPLIT_EN
        ACC2 = 2'd2,
`endif
        RESP = 2'd3
    } state_t;

    state_t state;

    // Latched request fields; only the address bits that index the array are kept.
    logic          we_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
`ifdef MISALIGN_SPLIT_EN
    logic [31:0]   buf_lo;
`endif

    logic [31:0] mem [WORDS];

    logic [2:0]       req_nbytes;
    logic             req_fault;
    logic [3:0]       size_mask;
    logic [7:0]       lane_mask;
    logic [63:0]      lane_data;
    logic             second;
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      mem_word;
    logic [3:0]       wr_en;
    logic [31:0]      wr_data;
    logic [31:0]      lo_src;
    logic [31:0]      hi_src;
    logic [31:0]      ld_raw;
    logic [31:0]      ld_ext;

    assign dbg_state = state;
    assign mem_word  = mem[word_idx];

    // Fault decision on the incoming request; the end address is formed in 33 bits.
    always_comb begin
        case (req_size)
            2'b00:   req_nbytes = 3'd1;
            2'b01:   req_nbytes = 3'd2;
            default: req_nbytes = 3'd4;
        endcase
        req_fault = (req_size == 2'b11)
                 || (req_addr < 32'(PROT_LIMIT))
                 || (({1'b0, req_addr} + 33'(req_nbytes)) > 33'(DEPTH_BYTES));
`ifndef MISALIGN_SPLIT_EN
        if (req_size == 2'b01 && req_addr[0])
            req_fault = 1'b1;
        if (req_size == 2'b10 && req_addr[1:0] != 2'b00)
            req_fault = 1'b1;
`endif
    end

    // Byte lanes across the two touched words: low half for ACC, high half for ACC2.
    always_comb begin
        case (size_q)
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
        lane_mask = {4'b0000, size_mask} << addr_q[1:0];
        lane_data = {32'b0, wdata_q} << {addr_q[1:0], 3'b000};
        second    = 1'b0;
`ifdef MISALIGN_SPLIT_EN
        second    = (state == ACC2);
`endif
        word_idx  = addr_q[AW-1:2] + IDX_W'(second);
        wr_en     = 4'b0000;
        if (we_q && (state == ACC || second))
            wr_en = second ? lane_mask[7:4] : lane_mask[3:0];
        wr_data   = second ? lane_data[63:32] : lane_data[31:0];
    end

    // Load alignment and extension from the word pair {high word, low word}.
    always_comb begin
`ifdef MISALIGN_SPLIT_EN
        lo_src = second ? buf_lo : mem_word;
        hi_src = second ? mem_word : 32'b0;
`else
        lo_src = mem_word;
        hi_src = 32'b0;
`endif
        ld_raw = 32'({hi_src, lo_src} >> {addr_q[1:0], 3'b000});
        case (size_q)
            2'b00:   ld_ext = uns_q ? {24'b0, ld_raw[7:0]}  : {{24{ld_raw[7]}}, ld_raw[7:0]};
            2'b01:   ld_ext = uns_q ? {16'b0, ld_raw[15:0]} : {{16{ld_raw[15]}}, ld_raw[15:0]};
            default: ld_ext = ld_raw;
        endcase
    end

    // Array write port with per-byte enables; contents survive reset.
    always_ff @(posedge clk) begin
        for (int j = 0; j < 4; j++) begin
            if (wr_en[j])
                mem[word_idx][8*j +: 8] <= wr_data[8*j +: 8];
        end
    end

    // Access sequencer with registered handshake and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'b0;
            resp_fault <= 1'b0;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'b0;
`ifdef MISALIGN_SPLIT_EN
            buf_lo     <= 32'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        we_q      <= req_we;
                        size_q    <= req_size;
                        uns_q     <= req_unsigned;
                        addr_q    <= req_addr[AW-1:0];
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        if (req_fault) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            resp_rdata <= 32'b0;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                ACC: begin
`ifdef MISALIGN_SPLIT_EN
                    if (|lane_mask[7:4]) begin
                        buf_lo <= mem_word;
                        state  <= ACC2;
                    end else begin
`else
                    begin
`endif
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_fault <= 1'b0;
                        resp_rdata <= we_q ? 32'b0 : ld_ext;
                    end
                end
`ifdef MISALIGN_SPLIT_EN
                ACC2: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_fault <= 1'b0;
                    resp_rdata <= we_q ? 32'b0 : ld_ext;
                end
`endif
                RESP: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_fault <= 1'b0;
                    resp_rdata <= 32'b0;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed vector table, reset-abort sequences and randomized
// requests checked against a byte-array model of the memory.
module tb_data_mem_ctrl;

    localparam int DEPTH = 256;
    localparam int PROT  = 24;
`ifdef MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;

    logic [7:0] model_mem [DEPTH];

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    // Clock and DUT
    always #5 clk = ~clk;

    data_mem_ctrl #(.DEPTH_BYTES(DEPTH), .PROT_LIMIT(PROT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .dbg_state(dbg_state)
    );

    function automatic void check32(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endfunction

    // Reference model: byte-level memory and the access rules.
    function automatic void model_req(input logic we, input logic [1:0] size, input logic uns,
                                      input logic [31:0] addr, input logic [31:0] wdata,
                                      output logic [31:0] exp_rdata, output logic exp_fault,
                                      output int exp_lat);
        int nb;
        longint end_addr;
        logic [31:0] v;
        nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        end_addr = longint'(addr) + longint'(nb);
        exp_fault = (size == 2'd3) || (longint'(addr) < longint'(PROT)) || (end_addr > longint'(DEPTH))
                 || (!SPLIT && (longint'(addr) % longint'(nb) != 0));
        exp_rdata = 32'h0;
        exp_lat = 1;
        if (!exp_fault) begin
            exp_lat = ((longint'(addr) % 4) + longint'(nb) > 4) ? 3 : 2;
            if (we) begin
                for (int i = 0; i < nb; i++) model_mem[int'(addr) + i] = wdata[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < nb; i++) v[8*i +: 8] = model_mem[int'(addr) + i];
                if (!uns && nb == 1) v = {{24{v[7]}}, v[7:0]};
                if (!uns && nb == 2) v = {{16{v[15]}}, v[15:0]};
                exp_rdata = v;
            end
        end
    endfunction

    function automatic void add_vec(input logic we, input logic [1:0] size, input logic uns,
                                    input logic [31:0] addr, input logic [31:0] wdata,
                                    input logic [31:0] exp_rdata, input logic exp_fault, input int exp_lat);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_fault = exp_fault; v.exp_lat = exp_lat;
        vecs.push_back(v);
    endfunction

    // Driver: one request, bounded waits; lat counts cycles from acceptance (99 = timeout).
    task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic fault, output int lat,
                           output logic after_valid, output logic after_ready);
        int waits;
        waits = 0;
        @(negedge clk);
        while (!req_ready && waits < 10) begin
            @(negedge clk);
            waits++;
        end
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!resp_valid) lat = 99;
        rdata = resp_rdata;
        fault = resp_fault;
        @(posedge clk);
        #1;
        after_valid = resp_valid;
        after_ready = req_ready;
    endtask

    task automatic do_check(input string name, input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rdata, input logic exp_fault, input int exp_lat);
        logic [31:0] rd;
        logic flt, av, ar;
        int lat;
        run_req(we, size, uns, addr, wdata, rd, flt, lat, av, ar);
        check32({name, " rdata"}, rd, exp_rdata);
        check32({name, " fault"}, 32'(flt), 32'(exp_fault));
        check32({name, " latency"}, 32'(lat), 32'(exp_lat));
        check32({name, " pulse/ready"}, 32'({av, ar}), 32'd1);
    endtask

    // Reset asserted `extra` edges after acceptance: outputs clear at once, no late response.
    task automatic reset_mid(input string name, input logic we, input logic [1:0] size,
                             input logic [31:0] addr, input logic [31:0] wdata, input int extra);
        int seen;
        seen = 0;
        @(negedge clk);
        req_we = we; req_size = size; req_unsigned = 1'b0; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int k = 0; k < extra; k++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        check32({name, " valid in reset"}, 32'(resp_valid), 32'd0);
        check32({name, " ready in reset"}, 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (resp_valid) seen++;
        end
        check32({name, " late response"}, 32'(seen), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] er, wd, ad;
        logic ef, uns, we;
        logic [1:0] sz;
        int el, r;

        for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;

        // Reset state
        #12;
        check32("reset ready", 32'(req_ready), 32'd1);
        check32("reset valid", 32'(resp_valid), 32'd0);
        check32("reset rdata", resp_rdata, 32'h0);
        check32("reset fault", 32'(resp_fault), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Give every accessible byte a known value
        for (int a = PROT; a < DEPTH; a += 4) begin
            wd = $urandom;
            model_req(1'b1, 2'd2, 1'b0, 32'(a), wd, er, ef, el);
            do_check($sformatf("fill %0h", a), 1'b1, 2'd2, 1'b0, 32'(a), wd, er, ef, el);
        end

        // Directed vectors
        add_vec(1, 2, 0, 32'h40, 32'hDEADBEEF, 32'h0, 0, 2);
        add_vec(0, 2, 0, 32'h40, 32'h0, 32'hDEADBEEF, 0, 2);
        add_vec(0, 0, 0, 32'h43, 32'h0, 32'hFFFFFFDE, 0, 2);
        add_vec(0, 0, 1, 32'h43, 32'h0, 32'h000000DE, 0, 2);
        add_vec(0, 1, 0, 32'h40, 32'h0, 32'hFFFFBEEF, 0, 2);
        add_vec(0, 1, 1, 32'h42, 32'h0, 32'h0000DEAD, 0, 2);
        add_vec(1, 2, 0, 32'h44, 32'h55667788, 32'h0, 0, 2);
        add_vec(1, 2, 0, 32'h48, 32'h99AABBCC, 32'h0, 0, 2);
`ifdef MISALIGN_SPLIT_EN
        add_vec(1, 2, 0, 32'h46, 32'h11223344, 32'h0, 0, 3);
        add_vec(0, 2, 0, 32'h46, 32'h0, 32'h11223344, 0, 3);
        add_vec(0, 0, 1, 32'h46, 32'h0, 32'h44, 0, 2);
        add_vec(0, 0, 1, 32'h47, 32'h0, 32'h33, 0, 2);
        add_vec(0, 0, 1, 32'h48, 32'h0, 32'h22, 0, 2);
        add_vec(0, 0, 1, 32'h49, 32'h0, 32'h11, 0, 2);
        add_vec(0, 0, 1, 32'h44, 32'h0, 32'h88, 0, 2);
        add_vec(0, 0, 1, 32'h45, 32'h0, 32'h77, 0, 2);
        add_vec(0, 0, 1, 32'h4A, 32'h0, 32'hAA, 0, 2);
        add_vec(0, 1, 1, 32'h47, 32'h0, 32'h00002233, 0, 3);
        add_vec(0, 1, 0, 32'h43, 32'h0, 32'hFFFF88DE, 0, 3);
`else
        add_vec(0, 2, 0, 32'h46, 32'h0, 32'h0, 1, 1);
        add_vec(1, 2, 0, 32'h46, 32'h11223344, 32'h0, 1, 1);
        add_vec(0, 1, 1, 32'h46, 32'h0, 32'h00005566, 0, 2);
        add_vec(0, 0, 1, 32'h48, 32'h0, 32'hCC, 0, 2);
        add_vec(0, 1, 1, 32'h47, 32'h0, 32'h0, 1, 1);
`endif
        add_vec(1, 0, 0, 32'h10, 32'hA5, 32'h0, 1, 1);
        add_vec(0, 0, 0, 32'h17, 32'h0, 32'h0, 1, 1);
        add_vec(1, 0, 0, 32'h18, 32'h5A, 32'h0, 0, 2);
        add_vec(0, 0, 1, 32'h18, 32'h0, 32'h5A, 0, 2);
        add_vec(0, 2, 0, 32'hFE, 32'h0, 32'h0, 1, 1);
        add_vec(0, 2, 0, 32'hFFFFFFFC, 32'h0, 32'h0, 1, 1);
        add_vec(0, 3, 0, 32'h40, 32'h0, 32'h0, 1, 1);
        add_vec(1, 3, 0, 32'h40, 32'hFFFFFFFF, 32'h0, 1, 1);
        add_vec(0, 2, 0, 32'h40, 32'h0, 32'hDEADBEEF, 0, 2);
        add_vec(1, 1, 0, 32'hFE, 32'h1234, 32'h0, 0, 2);
        add_vec(0, 1, 1, 32'hFE, 32'h0, 32'h1234, 0, 2);
        add_vec(0, 0, 0, 32'hFF, 32'h0, 32'h12, 0, 2);
        add_vec(0, 0, 0, 32'h100, 32'h0, 32'h0, 1, 1);
        add_vec(0, 1, 0, 32'hFF, 32'h0, 32'h0, 1, 1);
        add_vec(1, 0, 0, 32'h41, 32'h80, 32'h0, 0, 2);
        add_vec(0, 0, 0, 32'h41, 32'h0, 32'hFFFFFF80, 0, 2);
        add_vec(0, 2, 0, 32'h40, 32'h0, 32'hDEAD80EF, 0, 2);

        foreach (vecs[i]) begin
            model_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, er, ef, el);
            do_check($sformatf("vec %0d", i), vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr,
                     vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_fault, vecs[i].exp_lat);
        end

        // Reset during ACC: the access is aborted, nothing is written
        reset_mid("rst load", 1'b0, 2'd2, 32'h40, 32'h0, 0);
        reset_mid("rst store", 1'b1, 2'd2, 32'h60, 32'h0BADF00D, 0);
        model_req(1'b0, 2'd2, 1'b0, 32'h60, 32'h0, er, ef, el);
        do_check("after rst store", 1'b0, 2'd2, 1'b0, 32'h60, 32'h0, er, ef, el);
`ifdef MISALIGN_SPLIT_EN
        // Reset during ACC2: bytes written in ACC stay committed
        reset_mid("rst split", 1'b1, 2'd2, 32'h52, 32'hCAFEF00D, 1);
        model_mem[32'h52] = 8'h0D;
        model_mem[32'h53] = 8'hF0;
        model_req(1'b0, 2'd2, 1'b0, 32'h50, 32'h0, er, ef, el);
        do_check("after rst split lo", 1'b0, 2'd2, 1'b0, 32'h50, 32'h0, er, ef, el);
        model_req(1'b0, 2'd2, 1'b0, 32'h54, 32'h0, er, ef, el);
        do_check("after rst split hi", 1'b0, 2'd2, 1'b0, 32'h54, 32'h0, er, ef, el);
`endif

        // Randomized requests against the model
        for (int n = 0; n < 400; n++) begin
            we  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            wd  = $urandom;
            r   = int'($urandom_range(0, 9));
            if (r == 0)      ad = $urandom;
            else if (r == 1) ad = 32'($urandom_range(0, PROT + 4));
            else if (r == 2) ad = 32'(DEPTH - 4 + int'($urandom_range(0, 7)));
            else             ad = 32'($urandom_range(PROT, DEPTH - 1));
            model_req(we, sz, uns, ad, wd, er, ef, el);
            do_check($sformatf("rand %0d", n), we, sz, uns, ad, wd, er, ef, el);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
